// File: rtl/timer_pkg.sv
// Shared defaults, W1C bit-offset helpers and tcmp channel slicing for the timer interrupt block.
package timer_pkg;

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_CNT_W  = 64;
   localparam int ST_CLR_LSB = 0;

   // int_ovf clear bits sit directly above the int_st clear bits.
   function automatic int ovf_clr_lsb(input int num_ch);
      return ST_CLR_LSB + num_ch;
   endfunction

   // LSB of channel ch inside the packed tcmp bus.
   function automatic int tcmp_lsb(input int ch, input int cnt_w);
      return ch * cnt_w;
   endfunction

endpackage

// File: rtl/timer_int_ch.sv
// One compare channel: equality edge detect, W1C pending bit, optional missed-event flag.
// Event to int_st is one cycle; int_ovf exists only when TIMER_INT_OVF_EN is defined.
module timer_int_ch
   import timer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [CNT_W-1:0] tcmp_i,
   input  logic             clr_st_i,
   input  logic             clr_ovf_i,
   output logic             int_st_o,
   output logic             int_ovf_o
);

   logic match;
   logic ev;
   logic match_q;
   logic int_st_q;
   logic int_st_d;

   assign match = (cnt_i == tcmp_i);
   assign ev    = match & ~match_q;

   // A new event beats a clear in the same cycle.
   always_comb begin
      int_st_d = int_st_q;
      if (ev) begin
         int_st_d = 1'b1;
      end else if (clr_st_i) begin
         int_st_d = 1'b0;
      end
   end

   // match_q resets high so equality already present at reset release is not an event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_q  <= 1'b1;
         int_st_q <= 1'b0;
      end else begin
         match_q  <= match;
         int_st_q <= int_st_d;
      end
   end

   assign int_st_o = int_st_q;

`ifdef TIMER_INT_OVF_EN
   logic int_ovf_q;
   logic int_ovf_d;

   always_comb begin
      int_ovf_d = int_ovf_q;
      if (ev && int_st_q && !clr_st_i) begin
         int_ovf_d = 1'b1;
      end else if (clr_ovf_i) begin
         int_ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_ovf_q <= 1'b0;
      end else begin
         int_ovf_q <= int_ovf_d;
      end
   end

   assign int_ovf_o = int_ovf_q;
`else
   logic unused_clr_ovf;
   assign unused_clr_ovf = clr_ovf_i;
   assign int_ovf_o      = 1'b0;
`endif

endmodule

// File: rtl/timer_int_ctrl.sv
// Multi-channel timer compare interrupt controller; optional missed-event flags via TIMER_INT_OVF_EN.
// Equality in cycle N shows in int_st at N+1; tim_int_ch/tim_int are combinational from int_st & int_en.
module timer_int_ctrl
   import timer_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int DATA_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [CNT_W-1:0]        cnt,
   input  logic [NUM_CH*CNT_W-1:0] tcmp,
   input  logic [NUM_CH-1:0]       int_en,
   input  logic                    tisr_wr_sel,
   input  logic [DATA_W-1:0]       pwdata,
   output logic [NUM_CH-1:0]       int_st,
   output logic [NUM_CH-1:0]       int_ovf,
   output logic [NUM_CH-1:0]       tim_int_ch,
   output logic                    tim_int
);

   localparam int OVF_LSB = ovf_clr_lsb(NUM_CH);

   logic [NUM_CH-1:0] clr_st;
   logic [NUM_CH-1:0] clr_ovf;
   logic              unused_pwdata;

   assign clr_st        = {NUM_CH{tisr_wr_sel}} & pwdata[ST_CLR_LSB +: NUM_CH];
   assign clr_ovf       = {NUM_CH{tisr_wr_sel}} & pwdata[OVF_LSB +: NUM_CH];
   assign unused_pwdata = ^pwdata;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timer_int_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .cnt_i     (cnt),
         .tcmp_i    (tcmp[tcmp_lsb(i, CNT_W) +: CNT_W]),
         .clr_st_i  (clr_st[i]),
         .clr_ovf_i (clr_ovf[i]),
         .int_st_o  (int_st[i]),
         .int_ovf_o (int_ovf[i])
      );
   end

   // Enable masks only the outputs; pending status keeps collecting while disabled.
   assign tim_int_ch = int_st & int_en;
   assign tim_int    = |tim_int_ch;

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Directed bench for timer_int_ctrl with NUM_CH=4, CNT_W=64; int_ovf expectations follow TIMER_INT_OVF_EN.
module tb_timer_int_ctrl;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 64;
   localparam int DATA_W = 32;
   localparam logic [63:0] BIG = 64'h1234_0000_0000_0000;
`ifdef TIMER_INT_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [CNT_W-1:0]        cnt;
   logic [NUM_CH*CNT_W-1:0] tcmp;
   logic [NUM_CH-1:0]       int_en;
   logic                    tisr_wr_sel;
   logic [DATA_W-1:0]       pwdata;
   logic [NUM_CH-1:0]       int_st;
   logic [NUM_CH-1:0]       int_ovf;
   logic [NUM_CH-1:0]       tim_int_ch;
   logic                    tim_int;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   timer_int_ctrl #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cnt         (cnt),
      .tcmp        (tcmp),
      .int_en      (int_en),
      .tisr_wr_sel (tisr_wr_sel),
      .pwdata      (pwdata),
      .int_st      (int_st),
      .int_ovf     (int_ovf),
      .tim_int_ch  (tim_int_ch),
      .tim_int     (tim_int)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tcmp(input int ch, input logic [63:0] v);
      tcmp[ch*CNT_W +: CNT_W] = v;
   endtask

   initial begin
      logic [63:0] v;
      logic [3:0]  exp_st;

      // 1: reset, with a match already present at release
      rst_n       = 1'b0;
      cnt         = '0;
      tcmp        = '0;
      int_en      = 4'hF;
      tisr_wr_sel = 1'b0;
      pwdata      = '0;
      repeat (3) begin
         tick();
         check("rst_st", int_st, 4'h0);
         check("rst_int", tim_int, 1'b0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("post_rst_st", int_st, 4'h0);
         check("post_rst_int", tim_int, 1'b0);
         check("post_rst_ovf", int_ovf, 4'h0);
      end

      // 2: single match on ch2 with a running counter, then W1C clear
      set_tcmp(0, BIG);
      set_tcmp(1, BIG);
      set_tcmp(2, 64'd100);
      set_tcmp(3, BIG);
      int_en = 4'b0100;
      for (int n = 95; n <= 104; n++) begin
         cnt = 64'(n);
         tick();
         check("t2_st", int_st, (n >= 100) ? 4'h4 : 4'h0);
         check("t2_int", tim_int, (n >= 100) ? 1'b1 : 1'b0);
      end
      cnt         = 64'd105;
      tisr_wr_sel = 1'b1;
      pwdata      = 32'h4;
      tick();
      tisr_wr_sel = 1'b0;
      pwdata      = '0;
      check("t2_clr_st", int_st, 4'h0);
      check("t2_clr_int", tim_int, 1'b0);

      // 3: counter held on ch0 compare for 20 cycles, clear at cycle 5
      int_en = 4'b0001;
      set_tcmp(2, BIG);
      set_tcmp(0, 64'd100);
      cnt = 64'd100;
      for (int k = 1; k <= 20; k++) begin
         if (k == 5) begin
            tisr_wr_sel = 1'b1;
            pwdata      = 32'h1;
         end
         tick();
         tisr_wr_sel = 1'b0;
         pwdata      = '0;
         check("t3_st", int_st, (k < 5) ? 4'h1 : 4'h0);
      end
      check("t3_ovf", int_ovf, 4'h0);

      // 4: clear collides with a fresh ch1 event; masking then late enable
      int_en = 4'b0000;
      set_tcmp(1, 64'd200);
      cnt = 64'd199;
      tick();
      check("t4_pre_st", int_st, 4'h0);
      cnt         = 64'd200;
      tisr_wr_sel = 1'b1;
      pwdata      = 32'h2;
      tick();
      tisr_wr_sel = 1'b0;
      pwdata      = '0;
      check("t4_setwins_st", int_st, 4'h2);
      check("t4_masked_int", tim_int, 1'b0);
      int_en = 4'b0010;
      #1;
      check("t4_en_int", tim_int, 1'b1);
      check("t4_en_ch", tim_int_ch, 4'h2);

      tisr_wr_sel = 1'b1;
      pwdata      = 32'hFF;
      tick();
      tisr_wr_sel = 1'b0;
      pwdata      = '0;
      check("t4_clrall_st", int_st, 4'h0);

      // 5: ch0=0, ch1=ch2=5, ch3=all ones, counter wraps
      int_en = 4'hF;
      set_tcmp(0, 64'd0);
      set_tcmp(1, 64'd5);
      set_tcmp(2, 64'd5);
      set_tcmp(3, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int idx = 0; idx <= 10; idx++) begin
         v   = 64'hFFFF_FFFF_FFFF_FFFD + 64'(idx);
         cnt = v;
         tick();
         exp_st = ((idx >= 2) ? 4'h8 : 4'h0) | ((idx >= 3) ? 4'h1 : 4'h0) |
                  ((idx >= 8) ? 4'h6 : 4'h0);
         check("t5_st", int_st, exp_st);
         check("t5_int", tim_int, (idx >= 2) ? 1'b1 : 1'b0);
      end
      check("t5_ovf", int_ovf, 4'h0);

      // 6: second ch0 event while still pending
      cnt = 64'd0;
      tick();
      check("t6_st", int_st, 4'hF);
      check("t6_ovf_set", int_ovf, {3'b000, OVF_ON});
      tisr_wr_sel = 1'b1;
      pwdata      = 32'h10;
      cnt         = 64'd8;
      tick();
      tisr_wr_sel = 1'b0;
      pwdata      = '0;
      check("t6_ovf_clr", int_ovf, 4'h0);
      check("t6_st_kept", int_st, 4'hF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
